mem_stage: RTL

Memory-access stage that consumes the execute stage's outputs. It holds them in an EX/MEM pipeline register and resolves branches. It performs sized loads and stores over a request/ready data-memory handshake, stalling upstream while an access is outstanding. It presents a registered result to write-back through a MEM/WB register.

---
 rtl/mem_stage_if.sv | 12 +
 rtl/mem_stage.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/ready bus between the memory stage (master) and data memory (slave).
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   modport master (output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, input dmem_rdata, dmem_ready);
   modport slave  (input dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, output dmem_rdata, dmem_ready);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, sized big-endian loads/stores with ready timeout, branch resolve, MEM/WB register.
module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWr,
   input  logic        MemtoReg,
   input  logic        RegWr,
   input  logic        Branch,
   input  logic        Zero,
   input  logic        Jump,
   input  logic        Jal,
   input  logic        Loadext,
   input  logic [1:0]  Dsize,
   input  logic [1:0]  FPoint,
   input  logic [31:0] ALUout,
   input  logic [31:0] BusB,
   input  logic [4:0]  Rw,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] NextAddress,
   mem_stage_if.master dmem,
   output logic        stall,
   output logic        take_branch,
   output logic [31:0] branch_target,
   output logic        wb_valid,
   output logic        wb_RegWr,
   output logic [4:0]  wb_Rw,
   output logic [31:0] wb_data,
   output logic [1:0]  wb_FPoint,
   output logic        mem_err
);
   typedef enum logic {IDLE, WAIT} state_t;
   typedef struct packed {
      logic        mem_wr, mem_to_reg, reg_wr, branch, zero, jal, loadext;
      logic [1:0]  dsize, fpoint;
      logic [31:0] alu, busb;
      logic [4:0]  rw;
      logic [31:0] btarget, next_addr;
   } exmem_t;
   localparam int CW = $clog2(TIMEOUT);

   exmem_t        ex_q, ex_d;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wb_valid_q, wb_valid_d, wb_regwr_q, wb_regwr_d, take_q, take_d, err_q, err_d;
   logic [4:0]    wb_rw_q, wb_rw_d;
   logic [1:0]    wb_fp_q, wb_fp_d;
   logic [31:0]   wb_data_q, wb_data_d, bt_q, bt_d;
   logic [1:0]    a;
   logic          memop, is_half, is_byte, is_word, mis, go, abort, done;
   logic [7:0]    ld_b;
   logic [15:0]   ld_h;
   logic [31:0]   ld;
   logic          unused_jump;

   assign unused_jump = Jump;
   assign dmem.dmem_req   = go;
   assign dmem.dmem_we    = go & ex_q.mem_wr;
   assign dmem.dmem_addr  = go ? {ex_q.alu[31:2], 2'b00} : '0;
   assign dmem.dmem_be    = ~go ? 4'b0000 : is_byte ? 4'b1000 >> a : is_half ? (a[1] ? 4'b0011 : 4'b1100) : 4'b1111;
   assign dmem.dmem_wdata = ~go ? '0 : is_byte ? {4{ex_q.busb[7:0]}} : is_half ? {2{ex_q.busb[15:0]}} : ex_q.busb;

   always_comb begin
      a = ex_q.alu[1:0];
      memop = ex_q.mem_wr | ex_q.mem_to_reg;
      is_half = ex_q.dsize == 2'b01;
      is_byte = ex_q.dsize == 2'b10;
      is_word = ex_q.dsize[1] == ex_q.dsize[0];
      mis = memop & ((is_half & a[0]) | (is_word & (a != 2'b00)));
      go = memop & ~mis;
      // give up on the TIMEOUT-th cycle the request has been presented
      abort = (state_q == WAIT) & ~dmem.dmem_ready & (cnt_q == CW'(TIMEOUT - 2));
      stall = go & ~dmem.dmem_ready & ~abort;
      done = ~stall & ~mis & ~abort;
      ld_b = 8'(dmem.dmem_rdata >> {~a, 3'b000});
      ld_h = a[1] ? dmem.dmem_rdata[15:0] : dmem.dmem_rdata[31:16];
      ld = is_byte ? {{24{ex_q.loadext & ld_b[7]}}, ld_b}
         : is_half ? {{16{ex_q.loadext & ld_h[15]}}, ld_h} : dmem.dmem_rdata;
      ex_d = stall ? ex_q : {MemWr, MemtoReg, RegWr, Branch, Zero, Jal, Loadext, Dsize, FPoint,
                             ALUout, BusB, Rw, BranchTarget, NextAddress};
      if (state_q == IDLE) state_d = (go & ~dmem.dmem_ready) ? WAIT : IDLE;
      else state_d = (dmem.dmem_ready | abort) ? IDLE : WAIT;
      cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
      wb_valid_d = done;
      wb_regwr_d = done & ex_q.reg_wr & ~ex_q.mem_wr;
      wb_rw_d = done ? ex_q.rw : '0;
      wb_fp_d = done ? ex_q.fpoint : '0;
      wb_data_d = ~done ? '0 : ex_q.mem_to_reg ? ld : ex_q.jal ? ex_q.next_addr : ex_q.alu;
      take_d = ~stall & ex_q.branch & ex_q.zero;
      bt_d = stall ? bt_q : ex_q.btarget;
      err_d = mis | abort;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q <= '0;
         state_q <= IDLE;
         cnt_q <= '0;
         wb_valid_q <= 1'b0;
         wb_regwr_q <= 1'b0;
         wb_rw_q <= '0;
         wb_fp_q <= '0;
         wb_data_q <= '0;
         take_q <= 1'b0;
         bt_q <= '0;
         err_q <= 1'b0;
      end else begin
         ex_q <= ex_d;
         state_q <= state_d;
         cnt_q <= cnt_d;
         wb_valid_q <= wb_valid_d;
         wb_regwr_q <= wb_regwr_d;
         wb_rw_q <= wb_rw_d;
         wb_fp_q <= wb_fp_d;
         wb_data_q <= wb_data_d;
         take_q <= take_d;
         bt_q <= bt_d;
         err_q <= err_d;
      end
   end

   assign take_branch = take_q;
   assign branch_target = bt_q;
   assign wb_valid = wb_valid_q;
   assign wb_RegWr = wb_regwr_q;
   assign wb_Rw = wb_rw_q;
   assign wb_data = wb_data_q;
   assign wb_FPoint = wb_fp_q;
   assign mem_err = err_q;
endmodule
